// File: rtl/tile_draw_engine.sv
// tile_draw_engine: draws one grid cell as a TILE x TILE RGB565 tile on an 8080 LCD bus.
// Optional GRID_OUTLINE_EN: background tiles get a grey outline on tile row 0 / column 0.
module tile_draw_engine #(
    parameter int TILE = 20,
    parameter int COLS = 16,
    parameter int ROWS = 12
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en_update,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] obj_code,
    output logic       cmd_done,
    output logic       busy,
    output logic       lcd_csx,
    output logic       lcd_dcx,
    output logic       lcd_wrx,
    output logic [7:0] lcd_d
);
    localparam int CW = $clog2(TILE);
    localparam logic [CW-1:0] LAST = CW'(TILE - 1);
    localparam logic [15:0] W_TILE = 16'(TILE);

    typedef enum logic [2:0] {
        S_IDLE, S_CASET, S_PASET, S_RAMWR, S_PIXELS, S_DONE, S_HOLD
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_x;
    logic [3:0]    r_y;
    logic [2:0]    r_code;
    logic          r_phase;
    logic [2:0]    r_bidx;
    logic          r_pbyte;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;

    logic [15:0]   w_xs;
    logic [15:0]   w_xe;
    logic [15:0]   w_ys;
    logic [15:0]   w_ye;
    logic [15:0]   w_color;
    logic          w_oor;
    logic          w_active;
    logic          w_last_px;

    assign w_xs = 16'(r_x) * W_TILE;
    assign w_xe = w_xs + W_TILE - 16'd1;
    assign w_ys = 16'(r_y) * W_TILE;
    assign w_ye = w_ys + W_TILE - 16'd1;
    assign w_oor = (32'(x) >= COLS) || (32'(y) >= ROWS);
    assign w_active = (r_state == S_CASET) || (r_state == S_PASET) ||
                      (r_state == S_RAMWR) || (r_state == S_PIXELS);
    assign w_last_px = r_pbyte && (r_row == LAST) && (r_col == LAST);

    // Address command sequence: cmd byte then start/end, MSB first.
    function automatic logic [7:0] addr_byte(
        input logic [2:0]  idx,
        input logic [7:0]  cmd,
        input logic [15:0] s,
        input logic [15:0] e
    );
        case (idx)
            3'd0:    addr_byte = cmd;
            3'd1:    addr_byte = s[15:8];
            3'd2:    addr_byte = s[7:0];
            3'd3:    addr_byte = e[15:8];
            default: addr_byte = e[7:0];
        endcase
    endfunction

    // Pixel colour from the latched object code (plus optional outline).
    always_comb begin
        w_color = 16'h0000;
        case (r_code)
            3'd1:    w_color = 16'h07E0;
            3'd2:    w_color = 16'h03E0;
            3'd3:    w_color = 16'hF800;
            3'd4:    w_color = 16'hFFFF;
            default: w_color = 16'h0000;
        endcase
`ifdef GRID_OUTLINE_EN
        if (((r_code == 3'd0) || (r_code >= 3'd5)) &&
            ((r_row == '0) || (r_col == '0)))
            w_color = 16'h2104;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and bus outputs; idle bus values are the defaults.
    always_comb begin
        w_next   = r_state;
        cmd_done = 1'b0;
        busy     = (r_state != S_IDLE);
        lcd_csx  = 1'b1;
        lcd_wrx  = 1'b1;
        lcd_dcx  = 1'b1;
        lcd_d    = 8'h00;
        if (w_active) begin
            lcd_csx = 1'b0;
            lcd_wrx = r_phase;
        end
        unique case (r_state)
            S_IDLE: begin
                if (en_update) w_next = w_oor ? S_DONE : S_CASET;
            end
            S_CASET: begin
                lcd_dcx = (r_bidx != 3'd0);
                lcd_d   = addr_byte(r_bidx, 8'h2A, w_xs, w_xe);
                if (r_phase && (r_bidx == 3'd4)) w_next = S_PASET;
            end
            S_PASET: begin
                lcd_dcx = (r_bidx != 3'd0);
                lcd_d   = addr_byte(r_bidx, 8'h2B, w_ys, w_ye);
                if (r_phase && (r_bidx == 3'd4)) w_next = S_RAMWR;
            end
            S_RAMWR: begin
                lcd_dcx = 1'b0;
                lcd_d   = 8'h2C;
                if (r_phase) w_next = S_PIXELS;
            end
            S_PIXELS: begin
                lcd_d = r_pbyte ? w_color[7:0] : w_color[15:8];
                if (r_phase && w_last_px) w_next = S_DONE;
            end
            S_DONE: begin
                cmd_done = 1'b1;
                w_next   = S_HOLD;
            end
            S_HOLD: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch plus byte/phase and pixel row/column counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_code  <= '0;
            r_phase <= 1'b0;
            r_bidx  <= '0;
            r_pbyte <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
        end else if (r_state == S_IDLE) begin
            r_phase <= 1'b0;
            r_bidx  <= '0;
            r_pbyte <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            if (en_update) begin
                r_x    <= x;
                r_y    <= y;
                r_code <= obj_code;
            end
        end else if (w_active) begin
            r_phase <= ~r_phase;
            if (r_phase && ((r_state == S_CASET) || (r_state == S_PASET)))
                r_bidx <= (r_bidx == 3'd4) ? 3'd0 : r_bidx + 3'd1;
            if (r_phase && (r_state == S_PIXELS)) begin
                r_pbyte <= ~r_pbyte;
                if (r_pbyte) begin
                    if (r_col == LAST) begin
                        r_col <= '0;
                        r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tile_draw_engine.sv
// tb_tile_draw_engine: directed checks of tile_draw_engine bus bytes and handshake.
// Pixel outline checks follow GRID_OUTLINE_EN when the build defines it.
module tb_tile_draw_engine;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       en_update = 1'b0;
    logic [3:0] x = 4'd0;
    logic [3:0] y = 4'd0;
    logic [2:0] obj_code = 3'd0;
    logic       cmd_done;
    logic       busy;
    logic       lcd_csx;
    logic       lcd_dcx;
    logic       lcd_wrx;
    logic [7:0] lcd_d;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [8:0] bq[$];

    tile_draw_engine dut (
        .clk(clk), .nrst(nrst), .en_update(en_update),
        .x(x), .y(y), .obj_code(obj_code),
        .cmd_done(cmd_done), .busy(busy),
        .lcd_csx(lcd_csx), .lcd_dcx(lcd_dcx),
        .lcd_wrx(lcd_wrx), .lcd_d(lcd_d)
    );

    always #5 clk = ~clk;

    // Bus monitor: one entry {dcx,d} per write-strobe-low cycle.
    always @(negedge clk) begin
        if (!lcd_csx && !lcd_wrx) bq.push_back({lcd_dcx, lcd_d});
        if (cmd_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic run_tx(input logic [3:0] tx, input logic [3:0] ty,
                          input logic [2:0] tc, input bit scr,
                          output int n);
        x = tx;
        y = ty;
        obj_code = tc;
        bq.delete();
        en_update = 1'b1;
        n = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (scr && k == 5) begin
                x = 4'd0;
                y = 4'd0;
                obj_code = 3'd1;
            end
            if (cmd_done) begin
                n = k;
                break;
            end
        end
        en_update = 1'b0;
    endtask

    task automatic check_hdr(input string tag, input logic [15:0] xs,
                             input logic [15:0] xe, input logic [15:0] ys,
                             input logic [15:0] ye);
        logic [8:0] e[11];
        e = '{9'h02A, {1'b1, xs[15:8]}, {1'b1, xs[7:0]},
              {1'b1, xe[15:8]}, {1'b1, xe[7:0]},
              9'h02B, {1'b1, ys[15:8]}, {1'b1, ys[7:0]},
              {1'b1, ye[15:8]}, {1'b1, ye[7:0]}, 9'h02C};
        for (int i = 0; i < 11; i++)
            chk($sformatf("%s_hdr%0d", tag, i), 32'(bq[i]), 32'(e[i]));
    endtask

    task automatic check_pix(input string tag, input logic [15:0] c);
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (bq[11 + 2 * i] !== {1'b1, c[15:8]}) bad++;
            if (bq[12 + 2 * i] !== {1'b1, c[7:0]}) bad++;
        end
        chk($sformatf("%s_pix_bad", tag), 32'(bad), 32'd0);
    endtask

    initial begin
        int n;
        int d0;
        int zc;

        repeat (3) @(negedge clk);
        chk("rst_done", 32'(cmd_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_csx", 32'(lcd_csx), 32'd1);
        chk("rst_wrx", 32'(lcd_wrx), 32'd1);
        chk("rst_dcx", 32'(lcd_dcx), 32'd1);
        chk("rst_d", 32'(lcd_d), 32'd0);
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_nobus", 32'(bq.size()), 32'd0);

        run_tx(4'd0, 4'd0, 3'd1, 1'b0, n);
        chk("head_lat", 32'(n), 32'd1623);
        chk("head_nbytes", 32'(bq.size()), 32'd811);
        check_hdr("head", 16'd0, 16'd19, 16'd0, 16'd19);
        zc = 0;
        foreach (bq[i]) if (!bq[i][8]) zc++;
        chk("head_ncmd", 32'(zc), 32'd3);
        check_pix("head", 16'h07E0);
        @(negedge clk);
        chk("done_width", 32'(cmd_done), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("after_hold_busy", 32'(busy), 32'd0);

        run_tx(4'd15, 4'd11, 3'd4, 1'b1, n);
        chk("border_lat", 32'(n), 32'd1623);
        check_hdr("border", 16'h012C, 16'h013F, 16'h00DC, 16'h00EF);
        check_pix("border", 16'hFFFF);
        repeat (2) @(negedge clk);

        run_tx(4'd1, 4'd2, 3'd3, 1'b0, n);
        check_hdr("apple", 16'd20, 16'd39, 16'd40, 16'd59);
        check_pix("apple", 16'hF800);
        repeat (2) @(negedge clk);

        run_tx(4'd3, 4'd12, 3'd1, 1'b0, n);
        chk("oor_lat", 32'(n), 32'd1);
        chk("oor_nobus", 32'(bq.size()), 32'd0);
        repeat (2) @(negedge clk);

        x = 4'd3;
        y = 4'd12;
        en_update = 1'b1;
        @(negedge clk);
        chk("held_done1", 32'(cmd_done), 32'd1);
        @(negedge clk);
        chk("held_hold_done", 32'(cmd_done), 32'd0);
        chk("held_hold_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("held_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("held_done2", 32'(cmd_done), 32'd1);
        en_update = 1'b0;
        repeat (2) @(negedge clk);

        x = 4'd0;
        y = 4'd0;
        obj_code = 3'd1;
        en_update = 1'b1;
        repeat (100) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_csx_low", 32'(lcd_csx), 32'd0);
        d0 = done_cnt;
        nrst = 1'b0;
        #1;
        chk("abort_csx", 32'(lcd_csx), 32'd1);
        chk("abort_wrx", 32'(lcd_wrx), 32'd1);
        chk("abort_dcx", 32'(lcd_dcx), 32'd1);
        chk("abort_d", 32'(lcd_d), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        en_update = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_nodone", 32'(done_cnt - d0), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        run_tx(4'd2, 4'd3, 3'd0, 1'b0, n);
        chk("bg_lat", 32'(n), 32'd1623);
        check_hdr("bg", 16'd40, 16'd59, 16'd60, 16'd79);
`ifdef GRID_OUTLINE_EN
        chk("bg_p0_hi", 32'(bq[11]), 32'h121);
        chk("bg_p0_lo", 32'(bq[12]), 32'h104);
        chk("bg_p5_hi", 32'(bq[21]), 32'h121);
`else
        chk("bg_p0_hi", 32'(bq[11]), 32'h100);
        chk("bg_p0_lo", 32'(bq[12]), 32'h100);
        chk("bg_p5_hi", 32'(bq[21]), 32'h100);
`endif
        chk("bg_p21_hi", 32'(bq[53]), 32'h100);
        chk("bg_p21_lo", 32'(bq[54]), 32'h100);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
